fetch_op_queue: RTL

FETCH_OP_QUEUE -- requirements
Module: fetch_op_queue

---
 rtl/fetch_op_queue_pkg.sv | 35 +++
 rtl/foq_storage.sv | 25 ++
 rtl/fetch_op_queue.sv | 115 +++++++++++
 3 files changed

// File: rtl/fetch_op_queue_pkg.sv
// Shared definitions for the fetch-to-issue operation queue: depth default,
// op encodings and the packed entry layout that sets the storage width.
package fetch_op_queue_pkg;

    localparam int unsigned FOQ_DEPTH = 8;

    typedef enum logic [4:0] {
        OpLui    = 5'd0,
        OpAuipc  = 5'd1,
        OpJal    = 5'd2,
        OpJalr   = 5'd3,
        OpBranch = 5'd4,
        OpLoad   = 5'd5,
        OpStore  = 5'd6,
        OpAlu    = 5'd7,
        OpAluImm = 5'd8
    } op_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  op;
        logic        branch;
        logic        ls;
        logic        use_imm;
        logic        jalr;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        pred_taken;
    } foq_entry_t;

    localparam int unsigned ENTRY_W = $bits(foq_entry_t);

endpackage

// File: rtl/foq_storage.sv
// Entry array for the fetch op queue: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module foq_storage #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk_in,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fetch_op_queue.sv
// Circular queue of decoded instructions between fetch and issue, with
// back-pressure, global stall (rdy_in) and misprediction flush.
module fetch_op_queue
    import fetch_op_queue_pkg::*;
#(
    parameter int unsigned DEPTH = FOQ_DEPTH
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        in_valid,
    input  logic [31:0] in_pc,
    input  logic [4:0]  in_op,
    input  logic        in_branch,
    input  logic        in_ls,
    input  logic        in_use_imm,
    input  logic        in_jalr,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    input  logic        in_pred_taken,
    input  logic        predict_fail,
    output logic        foq_full,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [4:0]  out_op,
    output logic        out_branch,
    output logic        out_ls,
    output logic        out_use_imm,
    output logic [4:0]  out_rd,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [31:0] out_imm,
    output logic        out_jalr,
    output logic        out_pred_taken
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q;
    logic          push, pop;
    foq_entry_t    wr_entry, rd_entry;

    // Full comes from the registered count only, so a same-cycle pop never frees a slot early.
    assign foq_full  = (count_q == CW'(DEPTH));
    assign out_valid = (count_q != '0);

    assign push = rdy_in & in_valid & ~foq_full & ~predict_fail;
    assign pop  = rdy_in & out_valid & out_ready & ~predict_fail;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (rdy_in) begin
            if (predict_fail) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (push) tail_q <= tail_q + PW'(1);
                if (pop)  head_q <= head_q + PW'(1);
                if (push && !pop) begin
                    count_q <= count_q + CW'(1);
                end else if (pop && !push) begin
                    count_q <= count_q - CW'(1);
                end
            end
        end
    end

    assign wr_entry = '{
        pc:         in_pc,
        op:         in_op,
        branch:     in_branch,
        ls:         in_ls,
        use_imm:    in_use_imm,
        jalr:       in_jalr,
        rd:         in_rd,
        rs1:        in_rs1,
        rs2:        in_rs2,
        imm:        in_imm,
        pred_taken: in_pred_taken
    };

    foq_storage #(
        .DEPTH(DEPTH),
        .WIDTH(ENTRY_W)
    ) u_storage (
        .clk_in (clk_in),
        .wr_en  (push),
        .wr_addr(tail_q),
        .wr_data(wr_entry),
        .rd_addr(head_q),
        .rd_data(rd_entry)
    );

    assign out_pc         = rd_entry.pc;
    assign out_op         = rd_entry.op;
    assign out_branch     = rd_entry.branch;
    assign out_ls         = rd_entry.ls;
    assign out_use_imm    = rd_entry.use_imm;
    assign out_jalr       = rd_entry.jalr;
    assign out_rd         = rd_entry.rd;
    assign out_rs1        = rd_entry.rs1;
    assign out_rs2        = rd_entry.rs2;
    assign out_imm        = rd_entry.imm;
    assign out_pred_taken = rd_entry.pred_taken;

endmodule
